// File: rtl/mul_div_pkg.sv
// Shared encodings, FSM states and helpers for the sequential multiply/divide unit.
package mul_div_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    function automatic logic [MD_WIDTH-1:0] negate(input logic [MD_WIDTH-1:0] v);
        return ~v + MD_WIDTH'(1);
    endfunction

endpackage

// File: rtl/add_sub_w.sv
// Combinational N-bit adder/subtractor with carry out; carry=1 on subtract means x >= y.
module add_sub_w #(
    parameter int N = 33
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N-1:0] y_eff;

    assign y_eff       = sub ? ~y : y;
    assign {cout, sum} = {1'b0, x} + {1'b0, y_eff} + {{N{1'b0}}, sub};

endmodule

// File: rtl/mul_div_seq.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring on magnitudes),
// one bit per clock, HI/LO returned with a one-cycle done pulse.
module mul_div_seq
    import mul_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] bmag_r;
    logic             b_neg_r;
    // acc is one bit wider so that subtracting -2^(WIDTH-1) cannot overflow
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic             aux;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   add_x;
    logic [WIDTH:0]   add_y;
    logic             add_sub;
    logic [WIDTH:0]   add_sum;
    logic             add_cout;
    logic [WIDTH:0]   mul_acc;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // NOTE: every signal driven here is assigned on every path, so no latch is inferred.
    always_comb begin
        shifted = {acc[WIDTH-1:0], q[WIDTH-1]};
        if (op_r == OP_DIV) begin
            add_x   = shifted;
            add_y   = {1'b0, bmag_r};
            add_sub = 1'b1;
        end else begin
            add_x   = acc;
            add_y   = {a_r[WIDTH-1], a_r};
            add_sub = q[0];
        end
        mul_acc = (q[0] ^ aux) ? add_sum : acc;
        a_mag   = a[WIDTH-1] ? negate(a) : a;
        b_mag   = b[WIDTH-1] ? negate(b) : b;
        quo_fix = (a_r[WIDTH-1] ^ b_neg_r) ? negate(q) : q;
        rem_fix = a_r[WIDTH-1] ? negate(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    end

    add_sub_w #(.N(WIDTH + 1)) u_add_sub (
        .x    (add_x),
        .y    (add_y),
        .sub  (add_sub),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            op_r        <= OP_MUL;
            a_r         <= '0;
            bmag_r      <= '0;
            b_neg_r     <= 1'b0;
            acc         <= '0;
            q           <= '0;
            aux         <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_r        <= op;
                        a_r         <= a;
                        bmag_r      <= b_mag;
                        b_neg_r     <= b[WIDTH-1];
                        acc         <= '0;
                        q           <= (op == OP_DIV) ? a_mag : b;
                        aux         <= 1'b0;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        state       <= (op == OP_DIV && b == '0) ? FIX : RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (op_r == OP_DIV) begin
                        // keep the trial difference only when it did not borrow
                        acc <= add_cout ? add_sum : shifted;
                        q   <= {q[WIDTH-2:0], add_cout};
                    end else begin
                        {acc, q, aux} <= {mul_acc[WIDTH], mul_acc, q};
                    end
                    if (cnt == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                    if (op_r == OP_MUL) begin
                        hi <= acc[WIDTH-1:0];
                        lo <= q;
                    end else if (bmag_r == '0) begin
                        hi          <= a_r;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
